// File: rtl/seq_count_ctrl.sv
// seq_count_ctrl: start/done job controller around a 3-symbol overlapping
// pattern counter. It streams exactly len symbols from a valid/ready source
// and reports a saturating match count with a sticky overflow flag.
module seq_count_ctrl #(
    parameter int CNT_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             sym_valid,
    input  logic             sym,
    output logic             sym_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [2:0]       pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remaining;
    // Only the two most recent symbols are kept; the oldest history symbol
    // would fall out on the very shift that could use it.
    logic [1:0]       hist;
    logic [1:0]       fill;
    logic             xfer;
    logic             match;

    // Transfer and match are judged on the incoming symbol in the same cycle.
    always_comb begin
        xfer  = (state == RUN) && sym_valid;
        match = xfer && (fill >= 2'd2) && ({hist, sym} == pat_q);
    end

    // Job FSM with registered handshake/status outputs and the match counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            remaining <= '0;
            hist      <= '0;
            fill      <= '0;
            sym_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q <= pattern;
                        len_q <= len;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count     <= '0;
                    overflow  <= 1'b0;
                    hist      <= '0;
                    fill      <= '0;
                    remaining <= len_q;
                    if (len_q == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        sym_ready <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        hist      <= {hist[0], sym};
                        fill      <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
                        remaining <= remaining - 1'b1;
                        if (match) begin
                            if (count == CNT_MAX) overflow <= 1'b1;
                            else                  count    <= count + 1'b1;
                        end
                        // Last symbol of the job: its match lands with done.
                        if (remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            sym_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    sym_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_count_ctrl.sv
// Directed bench for seq_count_ctrl: table of jobs with hand-computed counts,
// plus a hand-written mid-run reset sequence.
module tb_seq_count_ctrl;

    localparam int CNT_W = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       pattern = '0;
    logic [LEN_W-1:0] len = '0;
    logic             sym_valid = 1'b0;
    logic             sym = 1'b0;
    logic             sym_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    int ntests = 0;
    int nfail  = 0;

    seq_count_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready), .busy(busy),
        .done(done), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] pat;
        int         n;
        string      syms;
        bit         gap;       // sym_valid low every other cycle
        bit         start_run; // hold start high during RUN and DONE
        int         exp_cnt;
        bit         exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one job; inputs driven and outputs sampled on negedges.
    // done_edge is the number of rising edges after the start edge at which
    // done first shows up.
    task automatic run_job(input vec_t v, output int done_edge, output int nready,
                           output int nbusy, output int last_xfer, output int nxfer,
                           output int cnt_at_done, output int ovf_at_done);
        int  idx;
        int  edges;
        bit  vtog;
        bit  x;
        idx = 0; edges = 0; vtog = 1'b1;
        done_edge = -1; nready = 0; nbusy = 0; last_xfer = -1;
        cnt_at_done = -1; ovf_at_done = -1;
        @(negedge clk);
        start = 1'b1; pattern = v.pat; len = LEN_W'(v.n); sym_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = v.start_run;
        pattern = ~v.pat; len = ~LEN_W'(v.n);
        while (edges < 200 && done_edge < 0) begin
            sym_valid = v.gap ? vtog : 1'b1;
            vtog = ~vtog;
            sym = (idx < v.syms.len()) ? (v.syms[idx] == "b") : 1'b0;
            x = sym_valid && sym_ready;
            if (sym_ready) nready++;
            if (busy) nbusy++;
            @(posedge clk);
            edges++;
            if (x) begin idx++; last_xfer = edges; end
            @(negedge clk);
            if (done) begin
                done_edge = edges;
                cnt_at_done = int'(count);
                ovf_at_done = int'(overflow);
            end
        end
        nxfer = idx;
        sym_valid = 1'b0;
        // start stays high across the DONE->IDLE edge when requested
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        check("idle_after_done", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        check("no_second_job", int'(busy), 0);
    endtask

    initial begin
        int de, nr, nb, lx, nx, c, o;
        vec_t v;
        vecs[0] = '{3'b011,  6, "abbabb",               1'b0, 1'b0,  2, 1'b0};
        vecs[1] = '{3'b111,  5, "bbbbb",                1'b0, 1'b0,  3, 1'b0};
        vecs[2] = '{3'b011,  3, "bbb",                  1'b0, 1'b0,  0, 1'b0};
        vecs[3] = '{3'b000,  0, "",                     1'b0, 1'b0,  0, 1'b0};
        vecs[4] = '{3'b000, 20, "aaaaaaaaaaaaaaaaaaaa", 1'b0, 1'b0, 15, 1'b1};
        vecs[5] = '{3'b011,  3, "abb",                  1'b0, 1'b0,  1, 1'b0};
        vecs[6] = '{3'b011,  4, "abbb",                 1'b1, 1'b1,  1, 1'b0};
        vecs[7] = '{3'b101,  5, "babab",                1'b0, 1'b0,  2, 1'b0};
        vecs[8] = '{3'b110,  4, "bbaa",                 1'b0, 1'b0,  1, 1'b0};

        // Reset state
        #1;
        check("rst_sym_ready", int'(sym_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        #22 reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            run_job(v, de, nr, nb, lx, nx, c, o);
            check($sformatf("v%0d_count", i), c, v.exp_cnt);
            check($sformatf("v%0d_overflow", i), o, int'(v.exp_ovf));
            check($sformatf("v%0d_nxfer", i), nx, v.n);
            check($sformatf("v%0d_busy_cycles", i), nb, de);
            check($sformatf("v%0d_ready_cycles", i), nr, de - 1);
            if (v.gap) check($sformatf("v%0d_done_after_last", i), de, lx);
            else       check($sformatf("v%0d_done_edge", i), de, v.n + 1);
        end

        // Reset in the middle of a 6-symbol job, after 3 transfers
        begin
            int xf;
            string s;
            s = "abbabb";
            xf = 0;
            @(negedge clk);
            start = 1'b1; pattern = 3'b011; len = 8'd6;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 20 && xf < 3; k++) begin
                sym_valid = 1'b1;
                sym = (s[xf] == "b");
                if (sym_ready) begin
                    @(posedge clk); xf++;
                end else begin
                    @(posedge clk);
                end
                @(negedge clk);
            end
            sym_valid = 1'b0;
            check("mid_partial_count", int'(count), 1);
            check("mid_busy_before", int'(busy), 1);
            #2 reset = 1'b0;
            #1;
            check("mid_rst_count", int'(count), 0);
            check("mid_rst_busy", int'(busy), 0);
            check("mid_rst_ready", int'(sym_ready), 0);
            begin
                int seen_done;
                seen_done = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (done) seen_done++;
                end
                check("mid_rst_no_done", seen_done, 0);
            end
            reset = 1'b1;
            v = '{3'b011, 3, "abb", 1'b0, 1'b0, 1, 1'b0};
            run_job(v, de, nr, nb, lx, nx, c, o);
            check("post_rst_count", c, 1);
            check("post_rst_done_edge", de, 4);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
